// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, ALU op encodings, control bundle.
// Imported by the ID-stage logic and by later pipeline blocks.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       alu_src;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    // lw only writes rt, so only its base register can collide with a load
    function automatic logic op_uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/main_control.sv
// Combinational opcode-to-control decoder.
// Unknown opcodes decode to an all-zero bundle.
module main_control
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
                ctrl.reg_write = 1'b1;
            end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.mem_read   = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl.alu_op = ALUOP_SUB;
                ctrl.branch = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/ifid_decode.sv
// IF/ID register plus ID stage: decode, register file, load-use hazard.
// Outputs are combinational from instr_q and feed the IDEX register.
module ifid_decode
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter bit          RF_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] pc4,
    input  logic        flush,
    input  logic        idex_MemRead,
    input  logic [4:0]  idex_rt,
    input  logic        wb_RegWrite,
    input  logic [4:0]  wb_write_reg,
    input  logic [31:0] wb_write_data,
    output logic        pc_write,
    output logic        wb_RegWrite_id,
    output logic        wb_MemToReg_id,
    output logic        mem_MemRead_id,
    output logic        mem_MemWrite_id,
    output logic        ex_RegDst_id,
    output logic        ex_AluSrc_id,
    output logic        ex_branch_id,
    output logic [1:0]  ex_AluOp_id,
    output logic [31:0] pc4_out,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2,
    output logic [15:0] immediate,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd
);

    logic [31:0]       instr_q, instr_d;
    logic [31:0]       pc4_q, pc4_d;
    logic              valid_q, valid_d;
    logic [31:0][31:0] rf_q, rf_d;

    logic  [5:0] opcode;
    logic        stall;
    logic        bubble;
    logic        wr_en;
    ctrl_t       ctrl_dec;
    ctrl_t       ctrl_out;

    assign opcode    = instr_q[31:26];
    assign rs        = instr_q[25:21];
    assign rt        = instr_q[20:16];
    assign rd        = instr_q[15:11];
    assign immediate = instr_q[15:0];
    assign pc4_out   = pc4_q;

    always_comb begin
        stall = valid_q & idex_MemRead &
                ((idex_rt == rs) |
                 (op_uses_rt(opcode) & (idex_rt == rt)));
    end

    assign pc_write = ~stall | flush;
    assign bubble   = stall | ~valid_q;

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!stall) begin
            instr_d = instr;
            pc4_d   = pc4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    main_control u_main_control (
        .opcode (opcode),
        .ctrl   (ctrl_dec)
    );

    assign ctrl_out = bubble ? '0 : ctrl_dec;

    assign wb_RegWrite_id  = ctrl_out.reg_write;
    assign wb_MemToReg_id  = ctrl_out.mem_to_reg;
    assign mem_MemRead_id  = ctrl_out.mem_read;
    assign mem_MemWrite_id = ctrl_out.mem_write;
    assign ex_RegDst_id    = ctrl_out.reg_dst;
    assign ex_AluSrc_id    = ctrl_out.alu_src;
    assign ex_branch_id    = ctrl_out.branch;
    assign ex_AluOp_id     = ctrl_out.alu_op;

    assign wr_en = wb_RegWrite & (wb_write_reg != 5'd0);

    always_comb begin
        rf_d = rf_q;
        if (wr_en) begin
            rf_d[wb_write_reg] = wb_write_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_q <= '0;
        end else begin
            rf_q <= rf_d;
        end
    end

    // bypass is gated by reset so reads stay 0 while reset is held
    always_comb begin
        read_data1 = rf_q[rs];
        if (rs == 5'd0) begin
            read_data1 = '0;
        end else if (RF_BYPASS && reset && wr_en && wb_write_reg == rs) begin
            read_data1 = wb_write_data;
        end
    end

    always_comb begin
        read_data2 = rf_q[rt];
        if (rt == 5'd0) begin
            read_data2 = '0;
        end else if (RF_BYPASS && reset && wr_en && wb_write_reg == rt) begin
            read_data2 = wb_write_data;
        end
    end

endmodule

// File: tb/tb_ifid_decode.sv
// Self-checking bench for ifid_decode: directed steps then random traffic
// checked against a behavioural model of the IF/ID + ID stage.
module tb_ifid_decode;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        flush;
    logic        idex_MemRead;
    logic [4:0]  idex_rt;
    logic        wb_RegWrite;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        pc_write;
    logic        wb_RegWrite_id;
    logic        wb_MemToReg_id;
    logic        mem_MemRead_id;
    logic        mem_MemWrite_id;
    logic        ex_RegDst_id;
    logic        ex_AluSrc_id;
    logic        ex_branch_id;
    logic [1:0]  ex_AluOp_id;
    logic [31:0] pc4_out;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [15:0] immediate;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    bit          m_valid;
    logic [31:0] m_rf [32];

    ifid_decode dut (
        .clk             (clk),
        .reset           (reset),
        .instr           (instr),
        .pc4             (pc4),
        .flush           (flush),
        .idex_MemRead    (idex_MemRead),
        .idex_rt         (idex_rt),
        .wb_RegWrite     (wb_RegWrite),
        .wb_write_reg    (wb_write_reg),
        .wb_write_data   (wb_write_data),
        .pc_write        (pc_write),
        .wb_RegWrite_id  (wb_RegWrite_id),
        .wb_MemToReg_id  (wb_MemToReg_id),
        .mem_MemRead_id  (mem_MemRead_id),
        .mem_MemWrite_id (mem_MemWrite_id),
        .ex_RegDst_id    (ex_RegDst_id),
        .ex_AluSrc_id    (ex_AluSrc_id),
        .ex_branch_id    (ex_branch_id),
        .ex_AluOp_id     (ex_AluOp_id),
        .pc4_out         (pc4_out),
        .read_data1      (read_data1),
        .read_data2      (read_data2),
        .immediate       (immediate),
        .rs              (rs),
        .rt              (rt),
        .rd              (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, AluOp}
    function automatic logic [8:0] dut_ctrl();
        return {ex_RegDst_id, ex_AluSrc_id, wb_MemToReg_id, wb_RegWrite_id,
                mem_MemRead_id, mem_MemWrite_id, ex_branch_id, ex_AluOp_id};
    endfunction

    function automatic logic [8:0] m_ctrl(input logic [5:0] op);
        case (op)
            6'h00:   return 9'b1_0_0_1_0_0_0_10;
            6'h23:   return 9'b0_1_1_1_1_0_0_00;
            6'h2B:   return 9'b0_1_0_0_0_1_0_00;
            6'h04:   return 9'b0_0_0_0_0_0_1_01;
            default: return 9'b0;
        endcase
    endfunction

    function automatic bit m_stall();
        logic [5:0] op;
        bit         reads_rt;
        op       = m_instr[31:26];
        reads_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        return m_valid && idex_MemRead &&
               (idex_rt == m_instr[25:21] ||
                (reads_rt && idex_rt == m_instr[20:16]));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (!reset || idx == 5'd0) return 32'h0;
        if (wb_RegWrite && wb_write_reg == idx) return wb_write_data;
        return m_rf[idx];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    endtask

    task automatic check_outputs();
        bit         st;
        logic [8:0] ec;
        st = m_stall();
        ec = (st || !m_valid) ? 9'b0 : m_ctrl(m_instr[31:26]);
        chk("pc_write", {31'b0, pc_write}, {31'b0, (!st || flush)});
        chk("ctrl", {23'b0, dut_ctrl()}, {23'b0, ec});
        chk("pc4_out", pc4_out, m_pc4);
        chk("read_data1", read_data1, m_read(m_instr[25:21]));
        chk("read_data2", read_data2, m_read(m_instr[20:16]));
        chk("immediate", {16'b0, immediate}, {16'b0, m_instr[15:0]});
        chk("rs", {27'b0, rs}, {27'b0, m_instr[25:21]});
        chk("rt", {27'b0, rt}, {27'b0, m_instr[20:16]});
        chk("rd", {27'b0, rd}, {27'b0, m_instr[15:11]});
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] p,
                         input logic fl, input logic mr,
                         input logic [4:0] irt, input logic we,
                         input logic [4:0] wr, input logic [31:0] wd);
        instr         = i;
        pc4           = p;
        flush         = fl;
        idex_MemRead  = mr;
        idex_rt       = irt;
        wb_RegWrite   = we;
        wb_write_reg  = wr;
        wb_write_data = wd;
    endtask

    task automatic settle();
        #1;
        check_outputs();
    endtask

    task automatic advance();
        bit st;
        st = m_stall();
        if (wb_RegWrite && wb_write_reg != 5'd0) m_rf[wb_write_reg] = wb_write_data;
        if (flush) begin
            m_instr = 32'h0;
            m_valid = 1'b0;
        end else if (!st) begin
            m_instr = instr;
            m_pc4   = pc4;
            m_valid = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [5:0]  op;
        logic [31:0] ri;
        logic        mr;
        logic [4:0]  irt;
        logic [4:0]  wr;
        int          sel;

        reset = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        model_reset();
        settle();
        chk("rst_pc_write", {31'b0, pc_write}, 32'h1);
        chk("rst_ctrl", {23'b0, dut_ctrl()}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        drive(32'h00A0_0000, 32'h4, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        settle();
        advance();

        drive(32'h0000_0000, 32'h8, 0, 0, 5'd0, 1, 5'd5, 32'hDEAD_BEEF);
        settle();
        chk("bypass_r5", read_data1, 32'hDEAD_BEEF);
        advance();

        drive(32'h00A0_0000, 32'hC, 0, 0, 5'd0, 1, 5'd0, 32'h0000_1234);
        settle();
        chk("r0_write", read_data1, 32'h0);
        advance();

        drive(32'h010A_4820, 32'h10, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        settle();
        chk("stored_r5", read_data1, 32'hDEAD_BEEF);
        advance();

        drive(32'h8C83_0000, 32'h14, 0, 1, 5'd8, 0, 5'd0, 32'h0);
        settle();
        chk("lu_pc_write", {31'b0, pc_write}, 32'h0);
        chk("lu_ctrl", {23'b0, dut_ctrl()}, 32'h0);
        advance();

        drive(32'h8C83_0000, 32'h14, 0, 0, 5'd8, 0, 5'd0, 32'h0);
        settle();
        chk("lu_held_rs", {27'b0, rs}, 32'd8);
        chk("lu_after_ctrl", {23'b0, dut_ctrl()}, {23'b0, 9'b1_0_0_1_0_0_0_10});
        chk("lu_after_pc_write", {31'b0, pc_write}, 32'h1);
        advance();

        drive(32'h010A_4820, 32'h18, 0, 1, 5'd3, 0, 5'd0, 32'h0);
        settle();
        chk("nfs_pc_write", {31'b0, pc_write}, 32'h1);
        chk("nfs_ctrl", {23'b0, dut_ctrl()}, {23'b0, 9'b0_1_1_1_1_0_0_00});
        advance();

        drive(32'hAC22_0008, 32'h1C, 1, 1, 5'd8, 0, 5'd0, 32'h0);
        settle();
        chk("fl_pc_write", {31'b0, pc_write}, 32'h1);
        chk("fl_ctrl", {23'b0, dut_ctrl()}, 32'h0);
        advance();

        drive(32'hAC22_0008, 32'h1C, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        settle();
        chk("fl_next_ctrl", {23'b0, dut_ctrl()}, 32'h0);
        chk("fl_next_rs", {27'b0, rs}, 32'h0);
        advance();

        drive(32'h2000_0000, 32'h20, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        settle();
        chk("sw_ctrl", {23'b0, dut_ctrl()}, {23'b0, 9'b0_1_0_0_0_1_0_00});
        chk("sw_imm", {16'b0, immediate}, 32'h0008);
        chk("sw_rs", {27'b0, rs}, 32'd1);
        chk("sw_rt", {27'b0, rt}, 32'd2);
        advance();

        drive(32'h00A0_0000, 32'h24, 0, 0, 5'd0, 1, 5'd5, 32'h7);
        settle();
        chk("op08_ctrl", {23'b0, dut_ctrl()}, 32'h0);
        advance();

        drive(32'h0000_0000, 32'h28, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        settle();
        chk("pre_rst_r5", read_data1, 32'h7);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs();
        chk("mid_rst_rd1", read_data1, 32'h0);
        chk("mid_rst_ctrl", {23'b0, dut_ctrl()}, 32'h0);
        chk("mid_rst_pc_write", {31'b0, pc_write}, 32'h1);
        @(negedge clk);
        reset = 1'b1;

        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 4));
            case (sel)
                0:       op = 6'h00;
                1:       op = 6'h23;
                2:       op = 6'h2B;
                3:       op = 6'h04;
                default: op = 6'($urandom);
            endcase
            ri = {op, 26'($urandom)};
            mr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       irt = m_instr[25:21];
                1:       irt = m_instr[20:16];
                default: irt = 5'($urandom);
            endcase
            wr = ($urandom_range(0, 1) == 1) ? m_instr[25:21] : 5'($urandom);
            drive(ri, $urandom, ($urandom_range(0, 9) == 0), mr, irt,
                  1'($urandom_range(0, 1)), wr, $urandom);
            settle();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
